// File: rtl/branch_predictor_param.sv
// Next-fetch-PC predictor: direct-mapped BTB, 2-bit PHT (bimodal or gshare),
// and a circular return-address stack, trained by resolved instructions from EX.
module branch_predictor_param #(
    parameter int IDX_BITS  = 5,
    parameter int GHR_BITS  = 5,
    parameter int MODE      = 1,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] current_pc,
    output logic [31:0] predicted_pc,
    output logic        predicted_taken,
    input  logic        upd_valid,
    input  logic        upd_stall,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    input  logic        upd_is_branch,
    input  logic        upd_is_jump,
    input  logic        upd_is_call,
    input  logic        upd_is_ret,
    input  logic        upd_taken,
    input  logic        upd_mispredict,
    output logic [31:0] stat_updates,
    output logic [31:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 32 - IDX_BITS - 2;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        KIND_BRANCH = 2'b00,
        KIND_JUMP   = 2'b01,
        KIND_RET    = 2'b10
    } kind_t;

    logic              btb_valid_reg  [ENTRIES];
    logic [TAG_W-1:0]  btb_tag_reg    [ENTRIES];
    logic [31:0]       btb_target_reg [ENTRIES];
    kind_t             btb_kind_reg   [ENTRIES];
    logic [1:0]        pht_reg        [ENTRIES];
    logic [GHR_BITS-1:0] ghr_reg;

    logic [31:0]       ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_reg, ras_ptr_next, ras_ptr_inc, ras_ptr_dec, ras_waddr;
    logic [CNT_W-1:0]  ras_cnt_reg, ras_cnt_next;
    logic              ras_we;
    logic [31:0]       ras_wdata;

    logic [31:0]       stat_updates_reg, stat_mispredicts_reg;

    // Bits [1:0] of both PCs never reach the tables.
    logic unused_low_bits;
    assign unused_low_bits = ^{current_pc[1:0], upd_pc[1:0]};

    logic [IDX_BITS-1:0] ghr_ext;
    assign ghr_ext = IDX_BITS'(ghr_reg);

    // ---------------- prediction ----------------
    logic [IDX_BITS-1:0] pred_idx, pred_pht_idx;
    logic [TAG_W-1:0]    pred_tag;
    logic                pred_hit;

    assign pred_idx     = current_pc[IDX_BITS+1:2];
    assign pred_tag     = current_pc[31:IDX_BITS+2];
    assign pred_pht_idx = (MODE == 1) ? (pred_idx ^ ghr_ext) : pred_idx;
    assign pred_hit     = btb_valid_reg[pred_idx] && (btb_tag_reg[pred_idx] == pred_tag);

    always_comb begin
        predicted_pc    = current_pc + 32'd4;
        predicted_taken = 1'b0;
        if (reset && pred_hit) begin
            case (btb_kind_reg[pred_idx])
                KIND_JUMP: begin
                    predicted_taken = 1'b1;
                    predicted_pc    = btb_target_reg[pred_idx];
                end
                KIND_BRANCH: begin
                    if (pht_reg[pred_pht_idx][1]) begin
                        predicted_taken = 1'b1;
                        predicted_pc    = btb_target_reg[pred_idx];
                    end
                end
                KIND_RET: begin
                    predicted_taken = 1'b1;
                    predicted_pc    = (ras_cnt_reg != '0) ? ras_mem[ras_ptr_dec]
                                                          : btb_target_reg[pred_idx];
                end
                default: begin
                    predicted_taken = 1'b0;
                end
            endcase
        end
    end

    // ---------------- update decode ----------------
    logic                accept, eff_taken, btb_we, pht_we;
    logic [IDX_BITS-1:0] upd_idx, upd_pht_idx;
    logic [TAG_W-1:0]    upd_tag;
    kind_t               upd_kind;
    logic [1:0]          pht_cur, pht_next;

    assign accept      = upd_valid && !upd_stall && reset;
    assign eff_taken   = upd_is_jump || (upd_is_branch && upd_taken);
    assign btb_we      = accept && eff_taken;
    assign pht_we      = accept && upd_is_branch;
    assign upd_idx     = upd_pc[IDX_BITS+1:2];
    assign upd_tag     = upd_pc[31:IDX_BITS+2];
    assign upd_pht_idx = (MODE == 1) ? (upd_idx ^ ghr_ext) : upd_idx;
    assign upd_kind    = upd_is_ret ? KIND_RET : (upd_is_jump ? KIND_JUMP : KIND_BRANCH);
    assign pht_cur     = pht_reg[upd_pht_idx];

    always_comb begin
        pht_next = pht_cur;
        if (upd_taken) begin
            if (pht_cur != 2'b11) pht_next = pht_cur + 2'd1;
        end else begin
            if (pht_cur != 2'b00) pht_next = pht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid_reg[i] <= 1'b0;
                pht_reg[i]       <= 2'b01;
            end
            ghr_reg <= '0;
        end else begin
            if (btb_we) btb_valid_reg[upd_idx] <= 1'b1;
            if (pht_we) begin
                pht_reg[upd_pht_idx] <= pht_next;
                ghr_reg              <= (ghr_reg << 1) | GHR_BITS'(upd_taken);
            end
        end
    end

    // Payload fields need no reset: they are only read behind a valid bit.
    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_tag_reg[upd_idx]    <= upd_tag;
            btb_target_reg[upd_idx] <= upd_target;
            btb_kind_reg[upd_idx]   <= upd_kind;
        end
    end

    // ---------------- return address stack ----------------
    // ras_ptr_reg is the next free slot; the top of stack sits one below it.
    assign ras_ptr_inc = (ras_ptr_reg == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr_reg + PTR_W'(1);
    assign ras_ptr_dec = (ras_ptr_reg == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_ptr_reg - PTR_W'(1);
    assign ras_wdata   = upd_pc + 32'd4;

    always_comb begin
        ras_we       = 1'b0;
        ras_waddr    = ras_ptr_reg;
        ras_ptr_next = ras_ptr_reg;
        ras_cnt_next = ras_cnt_reg;
        if (accept) begin
            if (upd_is_call && upd_is_ret) begin
                ras_we = 1'b1;
                if (ras_cnt_reg == '0) begin
                    ras_ptr_next = ras_ptr_inc;
                    ras_cnt_next = CNT_W'(1);
                end else begin
                    ras_waddr = ras_ptr_dec;
                end
            end else if (upd_is_call) begin
                ras_we       = 1'b1;
                ras_ptr_next = ras_ptr_inc;
                if (ras_cnt_reg != CNT_W'(RAS_DEPTH)) ras_cnt_next = ras_cnt_reg + CNT_W'(1);
            end else if (upd_is_ret && (ras_cnt_reg != '0)) begin
                ras_ptr_next = ras_ptr_dec;
                ras_cnt_next = ras_cnt_reg - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ras_ptr_reg <= '0;
            ras_cnt_reg <= '0;
        end else begin
            ras_ptr_reg <= ras_ptr_next;
            ras_cnt_reg <= ras_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras_mem[ras_waddr] <= ras_wdata;
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (accept) begin
            if (stat_updates_reg != 32'hFFFF_FFFF)
                stat_updates_reg <= stat_updates_reg + 32'd1;
            if (upd_mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF))
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;

endmodule
